uart_fifo_bridge: RTL and testbench

Memory-mapped UART peripheral that connects the CPU's mem_valid/mem_ready bus to the byte-level uart core. It has a DEPTH-entry TX FIFO that a drain FSM feeds into the core's transmit/tx_byte interface, and a DEPTH-entry RX FIFO filled from received/rx_byte. The top level decodes the window (DATA at base+0, STATUS at base+4). This block sees only qualified mem_valid and uses only mem_addr[2].

---
 rtl/uart_fifo_bridge.sv | 170 +++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// Memory-mapped UART bridge: CPU mem_valid/mem_ready bus <-> byte-level uart core.
// TX FIFO drained by a kick/guard/wait FSM, RX FIFO filled from the core; DATA/STATUS selected by mem_addr[2].
module uart_fifo_bridge #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {B_IDLE, B_RESP} bus_state_t;
  typedef enum logic [1:0] {T_IDLE, T_KICK, T_GUARD, T_WAIT} tx_state_t;

  bus_state_t    r_bus_state;
  tx_state_t     r_tx_state;
  logic [7:0]    r_tx_mem [DEPTH];
  logic [7:0]    r_rx_mem [DEPTH];
  logic [PW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic          r_mem_ready;
  logic [31:0]   r_mem_rdata;
  logic          r_transmit;
  logic [7:0]    r_tx_byte;
  logic          r_rx_ovr, r_rx_err;

  logic        w_is_write, w_sel_status, w_accept;
  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_busy;
  logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic        w_clr_ovr, w_clr_err, w_set_ovr;
  logic [7:0]  w_tx_head, w_rx_head;
  logic [31:0] w_status, w_rd_data;
  logic        w_unused;

  assign w_unused = ^{mem_addr[31:3], mem_addr[1:0], mem_wdata[31:8]};

  // Full: same slot index, opposite lap bit. Empty: pointers identical.
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]) && (r_tx_wptr[AW] != r_tx_rptr[AW]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]) && (r_rx_wptr[AW] != r_rx_rptr[AW]);
  assign w_tx_head  = r_tx_mem[r_tx_rptr[AW-1:0]];
  assign w_rx_head  = r_rx_mem[r_rx_rptr[AW-1:0]];

  assign w_is_write   = |mem_wstrb;
  assign w_sel_status = mem_addr[2];
  assign w_accept     = (r_bus_state == B_IDLE) && mem_valid &&
                        !(w_is_write && !w_sel_status && w_tx_full);

  assign w_tx_push = w_accept && w_is_write && !w_sel_status;
  assign w_tx_pop  = (r_tx_state == T_KICK);
  assign w_rx_pop  = w_accept && !w_is_write && !w_sel_status && !w_rx_empty;
  assign w_rx_push = received && (!w_rx_full || w_rx_pop);
  assign w_set_ovr = received && w_rx_full && !w_rx_pop;
  assign w_clr_ovr = w_accept && w_is_write && w_sel_status && mem_wdata[3];
  assign w_clr_err = w_accept && w_is_write && w_sel_status && mem_wdata[4];

  assign w_tx_busy = !w_tx_empty || (r_tx_state != T_IDLE) || is_transmitting;
  assign w_status  = {27'h0, r_rx_err, r_rx_ovr, w_tx_full, w_tx_busy, !w_rx_empty};

  always_comb begin
    // NOTE: default assigned first so every path drives w_rd_data and no latch is inferred.
    w_rd_data = 32'h0;
    if (!w_is_write) begin
      if (w_sel_status)     w_rd_data = w_status;
      else if (!w_rx_empty) w_rd_data = {24'h0, w_rx_head};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_state <= B_IDLE;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'h0;
    end else begin
      case (r_bus_state)
        B_IDLE: begin
          if (w_accept) begin
            r_bus_state <= B_RESP;
            r_mem_ready <= 1'b1;
            r_mem_rdata <= w_rd_data;
          end
        end
        B_RESP: begin
          r_bus_state <= B_IDLE;
          r_mem_ready <= 1'b0;
        end
        default: begin
          r_bus_state <= B_IDLE;
          r_mem_ready <= 1'b0;
        end
      endcase
    end
  end

  // The guard cycle covers the core raising is_transmitting one cycle after the kick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= T_IDLE;
      r_transmit <= 1'b0;
      r_tx_byte  <= 8'h0;
    end else begin
      r_transmit <= 1'b0;
      case (r_tx_state)
        T_IDLE: begin
          if (!w_tx_empty && !is_transmitting) begin
            r_tx_state <= T_KICK;
            r_transmit <= 1'b1;
            r_tx_byte  <= w_tx_head;
          end
        end
        T_KICK:  r_tx_state <= T_GUARD;
        T_GUARD: r_tx_state <= T_WAIT;
        T_WAIT:  if (!is_transmitting) r_tx_state <= T_IDLE;
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= mem_wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PW'(1);
    end
  end

  // A new error/overflow event in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ovr <= 1'b0;
      r_rx_err <= 1'b0;
    end else begin
      if (w_set_ovr)      r_rx_ovr <= 1'b1;
      else if (w_clr_ovr) r_rx_ovr <= 1'b0;
      if (recv_error)     r_rx_err <= 1'b1;
      else if (w_clr_err) r_rx_err <= 1'b0;
    end
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
  assign transmit  = r_transmit;
  assign tx_byte   = r_tx_byte;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: queue-based reference model, a uart core model,
// and monitors that check bus responses and transmitted bytes as the DUT presents them.
module tb_uart_fifo_bridge;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_rdata;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting = 1'b0;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = 8'h0;
  logic        recv_error = 1'b0;

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
    .received(received), .rx_byte(rx_byte), .recv_error(recv_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] tx_q[$];
  logic [7:0] rx_m[$];
  bit         m_ovr = 0;
  bit         m_err = 0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int core_time = 10;
  bit hold_busy = 0;
  int busy_left = 0;
  int tx_pulses = 0;
  int last_kick_cyc = 0;
  int last_ready_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Bus response monitor
  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: rdata=%h with no request outstanding", mem_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk) check("rdata", mem_rdata, mon_e.val);
      end
    end
  end

  // uart core model: busy for core_time cycles after each transmit pulse; byte order checked here
  always @(negedge clk) begin
    if (transmit) begin
      tx_pulses++;
      last_kick_cyc = cyc;
      check("kick_while_busy", is_transmitting, 0);
      if (tx_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_transmit: tx_byte=%h expected no pulse", tx_byte);
      end else begin
        check("tx_byte", tx_byte, tx_q.pop_front());
      end
      busy_left = core_time;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    is_transmitting = hold_busy || (busy_left > 0);
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_addr(input bit sel_status);
    logic [31:0] a;
    a = $urandom;
    a[2] = sel_status;
    return a;
  endfunction

  function automatic logic [31:0] m_status(input bit tx_full, input bit tx_busy);
    return {27'h0, m_err, m_ovr, tx_full, tx_busy, rx_m.size() != 0};
  endfunction

  // Effects of core-side pulses landing in the same cycle as a bus access (applied after clears)
  task automatic m_events(input bit rx_now, input logic [7:0] rx_b, input bit err_now);
    if (err_now) m_err = 1;
    if (rx_now) begin
      if (rx_m.size() < DEPTH) rx_m.push_back(rx_b);
      else m_ovr = 1;
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input bit chk, input logic [31:0] want, input bit may_stall = 0,
                     input bit rx_now = 0, input logic [7:0] rx_b = 8'h0, input bit err_now = 0);
    int n;
    n = 0;
    exp_q.push_back('{chk, want});
    @(negedge clk);
    mem_valid = 1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    received = rx_now; rx_byte = rx_b; recv_error = err_now;
    do begin
      @(negedge clk);
      n++;
      received = 0; recv_error = 0;
    end while (!mem_ready && n < 500);
    last_ready_cyc = cyc;
    mem_valid = 0; mem_wstrb = 4'h0;
    if (!mem_ready) begin
      total++; bad++;
      $display("FAIL bus_timeout: no mem_ready after %0d cycles, addr=%h", n, addr);
    end else if (!may_stall) begin
      check("ready_latency", n, 1);
    end
    @(negedge clk);
    check("ready_one_pulse", mem_ready, 0);
  endtask

  task automatic read_data(input bit rx_now = 0, input logic [7:0] rx_b = 8'h0, input bit err_now = 0);
    logic [31:0] e;
    e = 32'h0;
    if (rx_m.size() != 0) e = {24'h0, rx_m.pop_front()};
    m_events(rx_now, rx_b, err_now);
    bus(rand_addr(0), $urandom, 4'h0, 1, e, 0, rx_now, rx_b, err_now);
  endtask

  task automatic read_status(input bit tx_full, input bit tx_busy, input bit rx_now = 0,
                             input logic [7:0] rx_b = 8'h0, input bit err_now = 0);
    logic [31:0] e;
    e = m_status(tx_full, tx_busy);
    m_events(rx_now, rx_b, err_now);
    bus(rand_addr(1), $urandom, 4'h0, 1, e, 0, rx_now, rx_b, err_now);
  endtask

  task automatic write_status(input logic [31:0] wd, input bit rx_now = 0,
                              input logic [7:0] rx_b = 8'h0, input bit err_now = 0);
    if (wd[3]) m_ovr = 0;
    if (wd[4]) m_err = 0;
    m_events(rx_now, rx_b, err_now);
    bus(rand_addr(1), wd, 4'(1 + $urandom_range(0, 14)), 0, 32'h0, 0, rx_now, rx_b, err_now);
  endtask

  task automatic write_data(input logic [7:0] b, input bit may_stall = 0);
    tx_q.push_back(b);
    bus(rand_addr(0), {24'($urandom), b}, 4'(1 + $urandom_range(0, 14)), 0, 32'h0, may_stall);
  endtask

  task automatic rx_inject(input logic [7:0] b);
    m_events(1, b, 0);
    @(negedge clk);
    received = 1; rx_byte = b;
    @(negedge clk);
    received = 0;
  endtask

  task automatic err_pulse();
    m_events(0, 8'h0, 1);
    @(negedge clk);
    recv_error = 1;
    @(negedge clk);
    recv_error = 0;
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || is_transmitting) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL tx_drain_timeout: %0d bytes still expected", tx_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int pulses_before;
    int n;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_transmit", transmit, 0);
    check("rst_tx_byte", tx_byte, 0);
    rst = 0;
    @(negedge clk);
    read_status(0, 0);
    read_data();

    // Three bytes through a core busy 10 cycles each; tx_busy stays up until the last completes
    core_time = 10;
    write_data(8'h41);
    write_data(8'h42);
    write_data(8'h43);
    read_status(0, 1);
    for (int i = 0; i < 40 && (tx_q.size() != 0 || busy_left > 3); i++) read_status(0, 1);
    wait_tx_drain();
    read_status(0, 0);

    // Nine writes against a held-busy core: the ninth stalls until the first pop
    hold_busy = 1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) write_data(8'($urandom));
    read_status(1, 1);
    pulses_before = tx_pulses;
    fork
      write_data(8'($urandom), 1);
      begin
        repeat (20) @(negedge clk);
        check("stall_ready_low", mem_ready, 0);
        check("stall_no_kick", tx_pulses, pulses_before);
        hold_busy = 0;
      end
    join
    check("accept_after_pop", last_ready_cyc - last_kick_cyc, 2);
    wait_tx_drain();
    read_status(0, 0);

    // RX overflow: nine bytes into eight slots
    for (int i = 0; i < 9; i++) rx_inject(8'(8'h10 + i));
    read_status(0, 0);
    for (int i = 0; i < 9; i++) read_data();
    write_status(32'h08);
    read_status(0, 0);

    // Full RX with a push landing on the same cycle as a DATA read
    for (int i = 0; i < DEPTH; i++) rx_inject(8'(8'h20 + i));
    read_data(1, 8'h28);
    read_status(0, 0);
    for (int i = 0; i < DEPTH; i++) read_data();

    // Empty RX with a push landing on the same cycle as a DATA read
    read_data(1, 8'h55);
    read_data();

    // Overflow set vs clear in the same cycle: set wins
    for (int i = 0; i < DEPTH; i++) rx_inject(8'(8'h60 + i));
    write_status(32'h08, 1, 8'h99);
    read_status(0, 0);
    for (int i = 0; i < DEPTH; i++) read_data();
    write_status(32'h08);

    // Framing error flag, clear, and set-wins on collision
    err_pulse();
    read_status(0, 0);
    write_status(32'h10);
    read_status(0, 0);
    write_status(32'h10, 0, 8'h0, 1);
    read_status(0, 0);
    write_status(32'h10);
    read_status(0, 0);

    // Randomized RX/STATUS traffic with coincident core pulses (TX idle)
    for (int i = 0; i < 200; i++) begin
      bit rx_now, err_now;
      rx_now  = ($urandom_range(0, 3) == 0);
      err_now = ($urandom_range(0, 15) == 0);
      b = 8'($urandom);
      case ($urandom_range(0, 6))
        0, 1, 2: rx_inject(b);
        3, 4:    read_data(rx_now, b, err_now);
        5:       read_status(0, 0, rx_now, b, err_now);
        default: write_status($urandom, rx_now, b, err_now);
      endcase
    end
    while (rx_m.size() != 0) read_data();
    write_status(32'h18);
    read_status(0, 0);

    // Randomized TX bursts with varying core busy time
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) core_time = $urandom_range(1, 12);
      write_data(8'($urandom), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_tx_drain();
    read_status(0, 0);

    // Reset while waiting on the core with bytes still queued
    core_time = 30;
    write_data(8'hA1);
    write_data(8'hA2);
    write_data(8'hA3);
    n = 0;
    while (tx_q.size() > 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("first_kick_before_reset", tx_q.size(), 2);
    repeat (5) @(negedge clk);
    pulses_before = tx_pulses;
    rst = 1;
    tx_q.delete();
    rx_m.delete();
    exp_q.delete();
    m_ovr = 0;
    m_err = 0;
    @(negedge clk);
    check("mid_rst_transmit", transmit, 0);
    check("mid_rst_tx_byte", tx_byte, 0);
    check("mid_rst_mem_ready", mem_ready, 0);
    rst = 0;
    read_status(0, 1);
    repeat (80) @(negedge clk);
    check("no_kick_after_reset", tx_pulses, pulses_before);
    read_status(0, 0);

    repeat (4) @(negedge clk);
    check("tx_all_sent", tx_q.size(), 0);
    check("responses_all_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
